// File: rtl/rr_lock_arbiter.sv
// rr_lock_arbiter: N-channel round-robin arbiter with packet lock and a
// registered output stage. Optional stall counter: RR_LOCK_ARBITER_STALL_CNT_EN.
module rr_lock_arbiter #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [N*W-1:0] in_bits,
    input  logic [N-1:0]   in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_bits,
    output logic           out_last,
    output logic [CW-1:0]  out_chosen
`ifdef RR_LOCK_ARBITER_STALL_CNT_EN
    ,
    output logic [15:0]    stall_cnt
`endif
);

    logic [CW-1:0] last_grant_q, last_grant_d;
    logic          locked_q, locked_d;
    logic [CW-1:0] lock_idx_q, lock_idx_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_bits_q, out_bits_d;
    logic          out_last_q, out_last_d;
    logic [CW-1:0] out_chosen_q, out_chosen_d;

    logic          hi_found, lo_found;
    logic [CW-1:0] hi_idx, lo_idx;
    logic [CW-1:0] sel;
    logic          sel_vld, sel_last;
    logic [W-1:0]  sel_bits;
    logic          space, fire;

    // Descending scan so the lowest qualifying index is the one kept.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i] && (CW'(i) > last_grant_q)) begin
                hi_found = 1'b1;
                hi_idx   = CW'(i);
            end
            if (in_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = CW'(i);
            end
        end
    end

    always_comb begin
        if (locked_q) begin
            sel = lock_idx_q;
        end else if (hi_found) begin
            sel = hi_idx;
        end else if (lo_found) begin
            sel = lo_idx;
        end else begin
            sel = last_grant_q;
        end
    end

    always_comb begin
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        sel_bits = '0;
        for (int i = 0; i < N; i++) begin
            if (CW'(i) == sel) begin
                sel_vld  = in_valid[i];
                sel_last = in_last[i];
                sel_bits = in_bits[i*W +: W];
            end
        end
    end

    assign space = !out_valid_q || out_ready;
    assign fire  = sel_vld && space;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = space && (CW'(i) == sel);
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        locked_d     = locked_q;
        lock_idx_d   = lock_idx_q;
        out_valid_d  = out_valid_q;
        out_bits_d   = out_bits_q;
        out_last_d   = out_last_q;
        out_chosen_d = out_chosen_q;
        if (fire) begin
            out_valid_d  = 1'b1;
            out_bits_d   = sel_bits;
            out_last_d   = sel_last;
            out_chosen_d = sel;
            last_grant_d = sel;
            locked_d     = !sel_last;
            if (!sel_last) begin
                lock_idx_d = sel;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= '0;
            locked_q     <= 1'b0;
            lock_idx_q   <= '0;
            out_valid_q  <= 1'b0;
            out_bits_q   <= '0;
            out_last_q   <= 1'b0;
            out_chosen_q <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            locked_q     <= locked_d;
            lock_idx_q   <= lock_idx_d;
            out_valid_q  <= out_valid_d;
            out_bits_q   <= out_bits_d;
            out_last_q   <= out_last_d;
            out_chosen_q <= out_chosen_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_bits   = out_bits_q;
    assign out_last   = out_last_q;
    assign out_chosen = out_chosen_q;

`ifdef RR_LOCK_ARBITER_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // A completed handshake restarts the count; stalls saturate.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && out_ready) begin
            stall_cnt_d = '0;
        end else if (out_valid_q && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed scoreboard bench for rr_lock_arbiter (N=4, W=8).
module tb_rr_lock_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_bits;
    logic [3:0]  in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_bits;
    logic        out_last;
    logic [1:0]  out_chosen;
`ifdef RR_LOCK_ARBITER_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    typedef struct {
        logic [7:0] b;
        logic       l;
        logic [1:0] c;
    } beat_t;

    beat_t q[$];
    int    passed;
    int    total;

    rr_lock_arbiter #(.N(4), .W(8)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_bits(in_bits),
        .in_last(in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bits(out_bits),
        .out_last(out_last),
        .out_chosen(out_chosen)
`ifdef RR_LOCK_ARBITER_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Drive one cycle from posedge+1; sample at the following negedge.
    task automatic step(input logic [3:0] v, input logic [3:0] l,
                        input logic ordy, input logic [3:0] exp_rdy);
        beat_t e;
        int    ch;
        in_valid  = v;
        in_last   = l;
        out_ready = ordy;
        @(negedge clk);
        chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            if (out_valid) begin
                chk("out_bits", {24'd0, out_bits}, {24'd0, q[0].b});
                chk("out_last", {31'd0, out_last}, {31'd0, q[0].l});
                chk("out_chosen", {30'd0, out_chosen}, {30'd0, q[0].c});
            end
            if (ordy) begin
                void'(q.pop_front());
            end
        end
        if ((v & exp_rdy) != 4'd0) begin
            ch = 0;
            for (int i = 0; i < 4; i++) begin
                if (exp_rdy[i]) ch = i;
            end
            e.b = in_bits[ch*8 +: 8];
            e.l = l[ch];
            e.c = 2'(ch);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        reset     = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_bits   = '0;
        out_ready = 1'b1;

        // Reset values with inputs toggling
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            in_valid = 4'b1111;
            in_last  = (k % 2 == 0) ? 4'hF : 4'h0;
            in_bits  = $urandom;
            #3;
            chk("rst_in_ready", {28'd0, in_ready}, 32'h2);
            chk("rst_out_valid", {31'd0, out_valid}, 32'h0);
            chk("rst_out_chosen", {30'd0, out_chosen}, 32'h0);
            chk("rst_out_bits", {24'd0, out_bits}, 32'h0);
            chk("rst_out_last", {31'd0, out_last}, 32'h0);
        end
        @(posedge clk);
        #1;
        reset    = 1'b1;
        in_valid = '0;
        in_bits  = 32'hA3A2A1A0;

        // Round-robin rotation 1,2,3,0,1
        step(4'b1111, 4'b1111, 1'b1, 4'b0010);
        step(4'b1111, 4'b1111, 1'b1, 4'b0100);
        step(4'b1111, 4'b1111, 1'b1, 4'b1000);
        step(4'b1111, 4'b1111, 1'b1, 4'b0001);
        step(4'b1111, 4'b1111, 1'b1, 4'b0010);
        step(4'b0000, 4'b0000, 1'b1, 4'b0010);
        step(4'b0000, 4'b0000, 1'b1, 4'b0010);

        // Channel 2 three-beat packet with a mid-packet gap
        in_bits[16 +: 8] = 8'hB0;
        step(4'b1111, 4'b1011, 1'b1, 4'b0100);
        step(4'b1011, 4'b1011, 1'b1, 4'b0100);
        step(4'b1011, 4'b1011, 1'b1, 4'b0100);
        in_bits[16 +: 8] = 8'hB1;
        step(4'b1111, 4'b1011, 1'b1, 4'b0100);
        in_bits[16 +: 8] = 8'hB2;
        step(4'b1111, 4'b1111, 1'b1, 4'b0100);
        step(4'b1111, 4'b1111, 1'b1, 4'b1000);
        step(4'b0000, 4'b0000, 1'b1, 4'b1000);

        // Backpressure: hold a beat for 5 cycles
        in_bits[0 +: 8] = 8'hC0;
        step(4'b0001, 4'b0001, 1'b1, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            step(4'b0010, 4'b0010, 1'b0, 4'b0000);
        end
`ifdef RR_LOCK_ARBITER_STALL_CNT_EN
        chk("stall_cnt_5", {16'd0, stall_cnt}, 32'd5);
`endif
        step(4'b0010, 4'b0010, 1'b1, 4'b0010);
`ifdef RR_LOCK_ARBITER_STALL_CNT_EN
        chk("stall_cnt_clr", {16'd0, stall_cnt}, 32'd0);
`endif
        step(4'b0000, 4'b0000, 1'b1, 4'b0010);

        // Idle gaps: channel 3 wins after channel 0 went last
        in_bits[0 +: 8]  = 8'hD0;
        in_bits[24 +: 8] = 8'hD3;
        step(4'b0001, 4'b0001, 1'b1, 4'b0001);
        step(4'b0000, 4'b0000, 1'b1, 4'b0001);
        step(4'b0000, 4'b0000, 1'b1, 4'b0001);
        step(4'b0000, 4'b0000, 1'b1, 4'b0001);
        step(4'b1001, 4'b1001, 1'b1, 4'b1000);
        step(4'b1001, 4'b1001, 1'b1, 4'b0001);
        step(4'b0000, 4'b0000, 1'b1, 4'b0001);

        // Reset in the middle of a channel-3 packet
        in_bits[24 +: 8] = 8'hE0;
        step(4'b1000, 4'b0000, 1'b1, 4'b1000);
        #2;
        reset    = 1'b0;
        in_valid = 4'b1010;
        in_last  = 4'b0000;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'h0);
        chk("mid_rst_out_bits", {24'd0, out_bits}, 32'h0);
        chk("mid_rst_out_chosen", {30'd0, out_chosen}, 32'h0);
        chk("mid_rst_out_last", {31'd0, out_last}, 32'h0);
        chk("mid_rst_in_ready", {28'd0, in_ready}, 32'h2);
`ifdef RR_LOCK_ARBITER_STALL_CNT_EN
        chk("mid_rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        in_bits[8 +: 8] = 8'hF1;
        step(4'b1010, 4'b1010, 1'b1, 4'b0010);
        step(4'b0000, 4'b0000, 1'b1, 4'b0010);
        step(4'b0000, 4'b0000, 1'b1, 4'b0010);

        chk("sb_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
